// File: rtl/regfile_writeback_pkg.sv
// Shared defaults and helpers for the register-file write-back front end.
// Each entry is stored as {addr, data}, with the address in the upper bits.
package regfile_writeback_pkg;

  localparam int WB_DEPTH_DEF  = 4;
  localparam int WB_DATA_W_DEF = 32;
  localparam int WB_ADDR_W_DEF = 5;

  // Width that holds 0..depth inclusive, for a power-of-two depth.
  function automatic int wb_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order write FIFO: two ordered push ports (push0 is older), one pop port,
// and an age-ordered view of every slot (index 0 is the head).
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEF,
  parameter int ENT_W = WB_ADDR_W_DEF + WB_DATA_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = wb_cnt_w(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push0_en,
  input  logic [ENT_W-1:0]            push0_entry,
  input  logic                        push1_en,
  input  logic [ENT_W-1:0]            push1_entry,
  input  logic                        pop,
  output logic [CNT_W-1:0]            count,
  output logic [DEPTH-1:0]            ent_valid,
  output logic [DEPTH-1:0][ENT_W-1:0] ent_entry
);

  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            wp;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][ENT_W-1:0] slot_q, slot_d;
  logic                        do_pop;

  assign do_pop = pop && (count_q != '0);

  // Pop is applied before the pushes so a push into the freed slot wins.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wp       = wr_ptr_q;
    valid_d  = valid_q;
    slot_d   = slot_q;
    if (do_pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (push0_en) begin
      slot_d[wp]  = push0_entry;
      valid_d[wp] = 1'b1;
      wp          = wp + PTR_W'(1);
    end
    if (push1_en) begin
      slot_d[wp]  = push1_entry;
      valid_d[wp] = 1'b1;
      wp          = wp + PTR_W'(1);
    end
    wr_ptr_d = wp;
    count_d  = count_q + CNT_W'(push0_en) + CNT_W'(push1_en) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      slot_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      slot_q   <= slot_d;
    end
  end

  always_comb begin
    ent_valid = '0;
    ent_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx          = rd_ptr_q + PTR_W'(i);
      ent_valid[i] = valid_q[idx];
      ent_entry[i] = slot_q[idx];
    end
  end

  assign count = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Write-side front end of the register file: mem/alu handshakes, ordered
// buffering, one drain per cycle, pending mask and optional bypass (WB_BYPASS_EN).
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH_DEF,
  parameter int DATA_W = WB_DATA_W_DEF,
  parameter int ADDR_W = WB_ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_addr,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_a3,
  output logic [DATA_W-1:0]      rf_wd,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  input  logic [ADDR_W-1:0]      byp_a1,
  input  logic [ADDR_W-1:0]      byp_a2,
  output logic                   byp_hit1,
  output logic                   byp_hit2,
  output logic [DATA_W-1:0]      byp_d1,
  output logic [DATA_W-1:0]      byp_d2
);

  localparam int CNT_W = wb_cnt_w(DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);

  logic [CNT_W-1:0]            count;
  logic [DEPTH-1:0]            ent_valid;
  logic [DEPTH-1:0][ENT_W-1:0] ent_entry;
  logic                        push0_en, push1_en;
  logic [ENT_W-1:0]            head_entry;

  // Ready looks only at the start-of-cycle count; a same-cycle drain never helps.
  assign mem_ready = count < DEPTH_C;
  assign alu_ready = (count < DEPTH_M1) || ((count < DEPTH_C) && !mem_valid);

  // Writes to x0 complete the handshake but never occupy a slot.
  assign push0_en = mem_valid && mem_ready && (mem_addr != '0);
  assign push1_en = alu_valid && alu_ready && (alu_addr != '0);

  wb_fifo #(
    .DEPTH (DEPTH),
    .ENT_W (ENT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push0_en    (push0_en),
    .push0_entry ({mem_addr, mem_data}),
    .push1_en    (push1_en),
    .push1_entry ({alu_addr, alu_data}),
    .pop         (rf_we),
    .count       (count),
    .ent_valid   (ent_valid),
    .ent_entry   (ent_entry)
  );

  assign fifo_full  = count == DEPTH_C;
  assign fifo_empty = count == '0;

  assign head_entry = ent_entry[0];
  assign rf_we      = ent_valid[0];
  assign rf_a3      = rf_we ? head_entry[ENT_W-1 -: ADDR_W] : '0;
  assign rf_wd      = rf_we ? head_entry[DATA_W-1:0] : '0;

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) busy[ent_entry[i][ENT_W-1 -: ADDR_W]] = 1'b1;
    end
    busy[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the last match, the youngest, wins.
  always_comb begin
    byp_hit1 = 1'b0;
    byp_hit2 = 1'b0;
    byp_d1   = '0;
    byp_d2   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (byp_a1 != '0) && (ent_entry[i][ENT_W-1 -: ADDR_W] == byp_a1)) begin
        byp_hit1 = 1'b1;
        byp_d1   = ent_entry[i][DATA_W-1:0];
      end
      if (ent_valid[i] && (byp_a2 != '0) && (ent_entry[i][ENT_W-1 -: ADDR_W] == byp_a2)) begin
        byp_hit2 = 1'b1;
        byp_d2   = ent_entry[i][DATA_W-1:0];
      end
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_a1, byp_a2};
  assign byp_hit1   = 1'b0;
  assign byp_hit2   = 1'b0;
  assign byp_d1     = '0;
  assign byp_d2     = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed and reference-queue bench for regfile_writeback (default parameters).
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ready, alu_valid, alu_ready;
  logic [4:0]  mem_addr, alu_addr, rf_a3, byp_a1, byp_a2;
  logic [31:0] mem_data, alu_data, rf_wd, busy, byp_d1, byp_d2;
  logic        rf_we, fifo_full, fifo_empty, byp_hit1, byp_hit2;

  int vecs = 0;
  int errs = 0;
  bit byp_en;

  always #5 clk = ~clk;

  regfile_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .rf_we      (rf_we),
    .rf_a3      (rf_a3),
    .rf_wd      (rf_wd),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .byp_a1     (byp_a1),
    .byp_a2     (byp_a2),
    .byp_hit1   (byp_hit1),
    .byp_hit2   (byp_hit2),
    .byp_d1     (byp_d1),
    .byp_d2     (byp_d2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    mem_addr  = '0;
    alu_addr  = '0;
    mem_data  = '0;
    alu_data  = '0;
  endtask

  task automatic test_reset();
    idle();
    byp_a1 = 5'd5;
    byp_a2 = 5'd6;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
    vecs++; if (rf_a3 !== 5'd0) begin errs++; $display("FAIL reset_rf_a3 got %0d want 0", rf_a3); end
    vecs++; if (rf_wd !== 32'd0) begin errs++; $display("FAIL reset_rf_wd got %h want 0", rf_wd); end
    vecs++; if (busy !== 32'd0) begin errs++; $display("FAIL reset_busy got %h want 0", busy); end
    vecs++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %0b want 1", fifo_empty); end
    vecs++; if (fifo_full !== 1'b0) begin errs++; $display("FAIL reset_full got %0b want 0", fifo_full); end
    vecs++; if ({byp_hit1, byp_hit2} !== 2'b00) begin errs++; $display("FAIL reset_byp_hit got %b want 00", {byp_hit1, byp_hit2}); end
    vecs++; if ({byp_d1, byp_d2} !== 64'd0) begin errs++; $display("FAIL reset_byp_d got %h want 0", {byp_d1, byp_d2}); end
    vecs++; if ({mem_ready, alu_ready} !== 2'b11) begin errs++; $display("FAIL reset_ready got %b want 11", {mem_ready, alu_ready}); end
  endtask

  task automatic test_single_write();
    mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 32'h1234_5678;
    #1;
    vecs++; if (mem_ready !== 1'b1) begin errs++; $display("FAIL single_mem_ready got %0b want 1", mem_ready); end
    tick();
    idle();
    #1;
    vecs++; if (rf_we !== 1'b1) begin errs++; $display("FAIL single_rf_we got %0b want 1", rf_we); end
    vecs++; if (rf_a3 !== 5'd5) begin errs++; $display("FAIL single_rf_a3 got %0d want 5", rf_a3); end
    vecs++; if (rf_wd !== 32'h1234_5678) begin errs++; $display("FAIL single_rf_wd got %h want 12345678", rf_wd); end
    vecs++; if (busy !== 32'h0000_0020) begin errs++; $display("FAIL single_busy got %h want 00000020", busy); end
    tick();
    vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL single_after_rf_we got %0b want 0", rf_we); end
    vecs++; if (busy !== 32'd0) begin errs++; $display("FAIL single_after_busy got %h want 0", busy); end
    vecs++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL single_after_empty got %0b want 1", fifo_empty); end
  endtask

  task automatic test_same_cycle_order();
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'hA;
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'hB;
    #1;
    vecs++; if ({mem_ready, alu_ready} !== 2'b11) begin errs++; $display("FAIL order_ready got %b want 11", {mem_ready, alu_ready}); end
    tick();
    idle();
    #1;
    vecs++; if ({rf_we, rf_a3, rf_wd} !== {1'b1, 5'd3, 32'hA}) begin errs++; $display("FAIL order_first got we=%0b a3=%0d wd=%h want we=1 a3=3 wd=a", rf_we, rf_a3, rf_wd); end
    vecs++; if (busy !== 32'h0000_0018) begin errs++; $display("FAIL order_busy2 got %h want 00000018", busy); end
    tick();
    vecs++; if ({rf_we, rf_a3, rf_wd} !== {1'b1, 5'd4, 32'hB}) begin errs++; $display("FAIL order_second got we=%0b a3=%0d wd=%h want we=1 a3=4 wd=b", rf_we, rf_a3, rf_wd); end
    vecs++; if (busy !== 32'h0000_0010) begin errs++; $display("FAIL order_busy1 got %h want 00000010", busy); end
    tick();
    vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL order_drained got %0b want 0", rf_we); end
  endtask

  // With one drain every cycle, occupancy settles at DEPTH-1: the alu path is
  // held off at count 3 while mem is valid, so fifo_full stays low here.
  task automatic test_full_fifo();
    logic [36:0] q[$];
    logic [31:0] exp_busy;
    logic        exp_mr, exp_ar;
    for (int cyc = 0; cyc < 116; cyc++) begin
      if (cyc < 8) begin
        mem_valid = 1'b1; mem_addr = 5'(cyc + 1);  mem_data = 32'h100 + 32'(cyc);
        alu_valid = 1'b1; alu_addr = 5'(cyc + 16); alu_data = 32'h200 + 32'(cyc);
      end else if (cyc < 108) begin
        mem_valid = ($urandom_range(0, 9) < 7); mem_addr = 5'($urandom_range(0, 31)); mem_data = $urandom;
        alu_valid = ($urandom_range(0, 9) < 7); alu_addr = 5'($urandom_range(0, 31)); alu_data = $urandom;
      end else begin
        idle();
      end
      #1;
      exp_mr = q.size() < 4;
      exp_ar = (q.size() < 3) || (q.size() < 4 && !mem_valid);
      exp_busy = '0;
      foreach (q[i]) exp_busy[q[i][36:32]] = 1'b1;
      exp_busy[0] = 1'b0;
      vecs++; if (mem_ready !== exp_mr) begin errs++; $display("FAIL fill_mem_ready cyc=%0d got %0b want %0b", cyc, mem_ready, exp_mr); end
      vecs++; if (alu_ready !== exp_ar) begin errs++; $display("FAIL fill_alu_ready cyc=%0d got %0b want %0b", cyc, alu_ready, exp_ar); end
      vecs++; if (busy !== exp_busy) begin errs++; $display("FAIL fill_busy cyc=%0d got %h want %h", cyc, busy, exp_busy); end
      vecs++; if ({fifo_full, fifo_empty} !== {q.size() == 4, q.size() == 0}) begin errs++; $display("FAIL fill_flags cyc=%0d got %b want %b", cyc, {fifo_full, fifo_empty}, {q.size() == 4, q.size() == 0}); end
      if (q.size() != 0) begin
        vecs++; if ({rf_we, rf_a3, rf_wd} !== {1'b1, q[0]}) begin errs++; $display("FAIL fill_head cyc=%0d got we=%0b a3=%0d wd=%h want we=1 a3=%0d wd=%h", cyc, rf_we, rf_a3, rf_wd, q[0][36:32], q[0][31:0]); end
      end else begin
        vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL fill_idle_we cyc=%0d got %0b want 0", cyc, rf_we); end
      end
      tick();
      if (q.size() != 0) void'(q.pop_front());
      if (mem_valid && exp_mr && mem_addr != 5'd0) q.push_back({mem_addr, mem_data});
      if (alu_valid && exp_ar && alu_addr != 5'd0) q.push_back({alu_addr, alu_data});
    end
    vecs++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL fill_final_empty got %0b want 1", fifo_empty); end
  endtask

  task automatic test_reg0();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF_FFFF;
    #1;
    vecs++; if (alu_ready !== 1'b1) begin errs++; $display("FAIL reg0_alu_ready got %0b want 1", alu_ready); end
    tick();
    idle();
    #1;
    vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL reg0_rf_we got %0b want 0", rf_we); end
    vecs++; if (busy !== 32'd0) begin errs++; $display("FAIL reg0_busy got %h want 0", busy); end
    vecs++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL reg0_empty got %0b want 1", fifo_empty); end
  endtask

  task automatic test_bypass();
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'd1;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'd2;
    byp_a1 = 5'd7; byp_a2 = 5'd0;
    #1;
    vecs++; if (byp_hit1 !== 1'b0) begin errs++; $display("FAIL byp_inflight got %0b want 0", byp_hit1); end
    tick();
    idle();
    #1;
    vecs++; if ({byp_hit1, byp_d1} !== {byp_en, byp_en ? 32'd2 : 32'd0}) begin errs++; $display("FAIL byp_youngest got hit=%0b d=%h want hit=%0b d=%h", byp_hit1, byp_d1, byp_en, byp_en ? 32'd2 : 32'd0); end
    vecs++; if (byp_hit2 !== 1'b0) begin errs++; $display("FAIL byp_addr0 got %0b want 0", byp_hit2); end
    byp_a2 = 5'd3;
    #1;
    vecs++; if (byp_hit2 !== 1'b0) begin errs++; $display("FAIL byp_nomatch got %0b want 0", byp_hit2); end
    tick();
    vecs++; if ({byp_hit1, byp_d1} !== {byp_en, byp_en ? 32'd2 : 32'd0}) begin errs++; $display("FAIL byp_after_pop got hit=%0b d=%h want hit=%0b d=%h", byp_hit1, byp_d1, byp_en, byp_en ? 32'd2 : 32'd0); end
    tick();
    vecs++; if ({byp_hit1, byp_d1} !== 33'd0) begin errs++; $display("FAIL byp_drained got hit=%0b d=%h want hit=0 d=0", byp_hit1, byp_d1); end
  endtask

  task automatic test_reset_mid();
    mem_valid = 1'b1; mem_addr = 5'd10; mem_data = 32'hA0;
    alu_valid = 1'b1; alu_addr = 5'd11; alu_data = 32'hB0;
    tick();
    mem_addr = 5'd12; mem_data = 32'hC0;
    alu_addr = 5'd13; alu_data = 32'hD0;
    tick();
    idle();
    #1;
    vecs++; if ({rf_we, rf_a3} !== {1'b1, 5'd11}) begin errs++; $display("FAIL rstmid_pre_head got we=%0b a3=%0d want we=1 a3=11", rf_we, rf_a3); end
    vecs++; if (busy !== 32'h0000_3800) begin errs++; $display("FAIL rstmid_pre_busy got %h want 00003800", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    vecs++; if (fifo_empty !== 1'b1) begin errs++; $display("FAIL rstmid_empty got %0b want 1", fifo_empty); end
    vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL rstmid_rf_we got %0b want 0", rf_we); end
    vecs++; if (busy !== 32'd0) begin errs++; $display("FAIL rstmid_busy got %h want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL rstmid_dropped cyc=%0d got we=%0b a3=%0d want we=0", i, rf_we, rf_a3); end
    end
  endtask

  initial begin
`ifdef WB_BYPASS_EN
    byp_en = 1'b1;
`else
    byp_en = 1'b0;
`endif
    rst = 1'b1;
    byp_a1 = '0;
    byp_a2 = '0;
    idle();
    test_reset();
    test_single_write();
    test_same_cycle_order();
    test_full_fifo();
    test_reg0();
    test_bypass();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
